// File: rtl/cs_pkg.sv
// Shared defaults, quadrant codes and quarter-wave ROM contents for cos_sine_pipe.
package cs_pkg;
    localparam int PHASE_W_DEF = 16;
    localparam int LUT_AW_DEF  = 8;
    localparam int OUT_W_DEF   = 16;
    localparam int MAG_W_DEF   = 15;

    typedef enum logic [1:0] {
        Q_0 = 2'd0,
        Q_1 = 2'd1,
        Q_2 = 2'd2,
        Q_3 = 2'd3
    } quad_t;

    localparam real HALF_PI = 1.5707963267948966;

    // Entry k of an n-step quarter sine, rounded and clipped to the largest positive Q1 value.
    function automatic int rom_entry(input int k, input int n, input int out_w);
        real v;
        int  r;
        int  lim;
        v   = $sin(HALF_PI * real'(k) / real'(n)) * (2.0 ** (out_w - 1));
        r   = $rtoi(v + 0.5);
        lim = (1 << (out_w - 1)) - 1;
        return (r > lim) ? lim : r;
    endfunction
endpackage

// File: rtl/cos_sine_qlut.sv
// Quarter-wave sine ROM with N+1 entries and two registered read ports (sine and cosine index).
module cos_sine_qlut
    import cs_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [LUT_AW:0]   i_si,
    input  logic [LUT_AW:0]   i_ci,
    output logic [OUT_W-1:0]  o_sin,
    output logic [OUT_W-1:0]  o_cos
);
    localparam int N = 1 << LUT_AW;

    logic [OUT_W-1:0] w_rom [0:N];
    logic [OUT_W-1:0] r_sin;
    logic [OUT_W-1:0] r_cos;

    for (genvar k = 0; k <= N; k++) begin : g_rom
        assign w_rom[k] = OUT_W'(rom_entry(k, N, OUT_W));
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_sin <= w_rom[i_si];
            r_cos <= w_rom[i_ci];
        end
    end

    assign o_sin = r_sin;
    assign o_cos = r_cos;
endmodule

// File: rtl/cos_sine_pipe.sv
// Four-stage phase-to-sin/cos pipeline (fold, ROM, sign, scale) with a globally stalled
// valid/ready handshake.
module cos_sine_pipe
    import cs_pkg::*;
#(
    parameter int PHASE_W  = PHASE_W_DEF,
    parameter int LUT_AW   = LUT_AW_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int MAG_W    = MAG_W_DEF,
    parameter int SCALE_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PHASE_W-1:0]       U1,
    input  logic [MAG_W-1:0]         mag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  g0,
    output logic signed [OUT_W-1:0]  g1
);
    localparam int N   = 1 << LUT_AW;
    localparam int PW  = OUT_W + MAG_W + 1;
    localparam int RND = 1 << (MAG_W - 1);

    logic                     w_en;
    quad_t                    w_q;
    logic [LUT_AW-1:0]        w_r;
    logic [LUT_AW:0]          w_si;
    logic [LUT_AW:0]          w_ci;
    logic [OUT_W-1:0]         w_rom_sin;
    logic [OUT_W-1:0]         w_rom_cos;
    logic                     w_neg_s;
    logic                     w_neg_c;
    logic signed [PW-1:0]     w_p0;
    logic signed [PW-1:0]     w_p1;
    logic signed [OUT_W-1:0]  w_g0;
    logic signed [OUT_W-1:0]  w_g1;

    logic                     r_v1, r_v2, r_v3, r_ov;
    quad_t                    r_q1, r_q2;
    logic [LUT_AW:0]          r_si1, r_ci1;
    logic [MAG_W-1:0]         r_mag1, r_mag2, r_mag3;
    logic signed [OUT_W-1:0]  r_sin3, r_cos3;
    logic signed [OUT_W-1:0]  r_g0, r_g1;

    assign w_en     = !r_ov || out_ready;
    assign in_ready = w_en;

    // Fold: odd quadrants walk the quarter wave backwards; cosine is the complementary index.
    assign w_q  = quad_t'(U1[PHASE_W-1 -: 2]);
    assign w_r  = U1[PHASE_W-3 -: LUT_AW];
    assign w_si = (w_q inside {Q_1, Q_3}) ? (LUT_AW+1)'(N) - {1'b0, w_r} : {1'b0, w_r};
    assign w_ci = (LUT_AW+1)'(N) - w_si;

    if (PHASE_W - 2 > LUT_AW) begin : g_trunc
        logic w_unused_lsb;
        assign w_unused_lsb = ^U1[PHASE_W-LUT_AW-3:0];
    end

    cos_sine_qlut #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_qlut (
        .clk    (clk),
        .i_en   (w_en && r_v1),
        .i_si   (r_si1),
        .i_ci   (r_ci1),
        .o_sin  (w_rom_sin),
        .o_cos  (w_rom_cos)
    );

    assign w_neg_s = r_q2 inside {Q_2, Q_3};
    assign w_neg_c = r_q2 inside {Q_1, Q_2};

    // ROM values never exceed the largest positive code, so the products and the
    // rounded, shifted results always fit OUT_W.
    assign w_p0 = PW'(r_sin3) * PW'($signed({1'b0, r_mag3}));
    assign w_p1 = PW'(r_cos3) * PW'($signed({1'b0, r_mag3}));
    assign w_g0 = (SCALE_EN != 0) ? OUT_W'((w_p0 + PW'(RND)) >>> MAG_W) : r_sin3;
    assign w_g1 = (SCALE_EN != 0) ? OUT_W'((w_p1 + PW'(RND)) >>> MAG_W) : r_cos3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_ov   <= 1'b0;
            r_q1   <= Q_0;
            r_q2   <= Q_0;
            r_si1  <= '0;
            r_ci1  <= '0;
            r_mag1 <= '0;
            r_mag2 <= '0;
            r_mag3 <= '0;
            r_sin3 <= '0;
            r_cos3 <= '0;
            r_g0   <= '0;
            r_g1   <= '0;
        end else if (w_en) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_ov <= r_v3;
            if (in_valid) begin
                r_q1   <= w_q;
                r_si1  <= w_si;
                r_ci1  <= w_ci;
                r_mag1 <= mag;
            end
            if (r_v1) begin
                r_q2   <= r_q1;
                r_mag2 <= r_mag1;
            end
            if (r_v2) begin
                r_sin3 <= w_neg_s ? -$signed(w_rom_sin) : $signed(w_rom_sin);
                r_cos3 <= w_neg_c ? -$signed(w_rom_cos) : $signed(w_rom_cos);
                r_mag3 <= r_mag2;
            end
            if (r_v3) begin
                r_g0 <= w_g0;
                r_g1 <= w_g1;
            end
        end
    end

    assign out_valid = r_ov;
    assign g0        = r_g0;
    assign g1        = r_g1;
endmodule

// File: tb/tb_cos_sine_pipe.sv
// Scoreboard bench for cos_sine_pipe: raw (SCALE_EN=0) and scaled (SCALE_EN=1) instances share stimulus.
module tb_cos_sine_pipe;
    import cs_pkg::*;

    localparam int PW = 16;
    localparam int AW = 8;
    localparam int OW = 16;
    localparam int MW = 15;
    localparam int NN = 256;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  out_ready = 1'b1;
    logic [PW-1:0]         U1 = '0;
    logic [MW-1:0]         mag = '0;
    logic                  rdy_r, rdy_s, ov_r, ov_s;
    logic signed [OW-1:0]  g0_r, g1_r, g0_s, g1_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rnd_done = 1'b0;

    typedef struct {
        logic [PW-1:0] u;
        logic [MW-1:0] m;
        int r0, r1, s0, s1;
        int acc;
        bit lat;
    } sb_t;

    sb_t sbq[$];

    cos_sine_pipe #(.PHASE_W(PW), .LUT_AW(AW), .OUT_W(OW), .MAG_W(MW), .SCALE_EN(0)) u_raw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r), .U1(U1), .mag(mag),
        .out_valid(ov_r), .out_ready(out_ready), .g0(g0_r), .g1(g1_r));

    cos_sine_pipe #(.PHASE_W(PW), .LUT_AW(AW), .OUT_W(OW), .MAG_W(MW), .SCALE_EN(1)) u_scl (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .U1(U1), .mag(mag),
        .out_valid(ov_s), .out_ready(out_ready), .g0(g0_s), .g1(g1_s));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int scale(input int t, input logic [MW-1:0] m);
        longint p;
        p = longint'(t) * longint'(m);
        return int'((p + 64'sd16384) >>> 15);
    endfunction

    function automatic sb_t model(input logic [PW-1:0] u, input logic [MW-1:0] m, input bit lat);
        sb_t e;
        int q, r, si, ci, s, c;
        q  = int'(u[15:14]);
        r  = int'(u[13:6]);
        si = (q == 1 || q == 3) ? NN - r : r;
        ci = NN - si;
        s  = rom_entry(si, NN, OW);
        c  = rom_entry(ci, NN, OW);
        if (q >= 2) s = -s;
        if (q == 1 || q == 2) c = -c;
        e.u = u; e.m = m; e.r0 = s; e.r1 = c;
        e.s0 = scale(s, m); e.s1 = scale(c, m);
        e.acc = 0; e.lat = lat;
        return e;
    endfunction

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic offer(input sb_t e);
        int budget;
        budget = 200;
        U1 = e.u; mag = e.m; in_valid = 1'b1;
        @(negedge clk);
        while (!rdy_s && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("accept_timeout", rdy_s, 1);
        else begin
            e.acc = cyc;
            sbq.push_back(e);
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [PW-1:0] u, input logic [MW-1:0] m, input bit lat);
        offer(model(u, m, lat));
    endtask

    task automatic send_exp(input logic [PW-1:0] u, input logic [MW-1:0] m,
                            input int r0, input int r1, input int s0, input int s1);
        sb_t e;
        e = model(u, m, 1'b1);
        e.r0 = r0; e.r1 = r1; e.s0 = s0; e.s1 = s1;
        offer(e);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sbq.size() > 0 && b < 100) begin
            @(posedge clk); #2;
            b++;
        end
        check("drain_empty", sbq.size(), 0);
    endtask

    logic signed [OW-1:0] h0r, h1r, h0s, h1s;
    bit stall_prev = 1'b0;

    always @(negedge clk) begin
        sb_t e;
        if (!rst) stall_prev = 1'b0;
        else begin
            check("in_ready_eq", rdy_s, !ov_s || out_ready);
            check("valid_match", ov_r, ov_s);
            if (stall_prev) begin
                check("hold_valid", ov_s, 1);
                check("hold_g0_raw", g0_r, h0r);
                check("hold_g1_raw", g1_r, h1r);
                check("hold_g0_scl", g0_s, h0s);
                check("hold_g1_scl", g1_s, h1s);
            end
            if (ov_s && out_ready) begin
                if (sbq.size() == 0) check("unexpected_out", ov_s, 0);
                else begin
                    e = sbq.pop_front();
                    check("g0_raw", g0_r, e.r0);
                    check("g1_raw", g1_r, e.r1);
                    check("g0_scl", g0_s, e.s0);
                    check("g1_scl", g1_s, e.s1);
                    if (e.lat) check("latency", cyc - e.acc, 4);
                end
            end
            stall_prev = ov_s && !out_ready;
            h0r = g0_r; h1r = g1_r; h0s = g0_s; h1s = g1_s;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(posedge clk); #2;
        check("rst_valid", ov_s, 0);
        check("rst_g0", g0_s, 0);
        check("rst_g1", g1_s, 0);
        check("rst_in_ready", rdy_s, 1);
        @(posedge clk); #2;
        rst = 1'b1;

        // Quadrant corners, mag near one
        send_exp(16'h0000, 15'h7FFF, 0, 32767, 0, 32766);
        send_exp(16'h4000, 15'h7FFF, 32767, 0, 32766, 0);
        send_exp(16'h8000, 15'h7FFF, 0, -32767, 0, -32766);
        send_exp(16'hC000, 15'h7FFF, -32767, 0, -32766, 0);
        drain();

        // Octants with half magnitude
        send_exp(16'h2000, 15'h4000, 23170, 23170, 11585, 11585);
        send_exp(16'hA000, 15'h4000, -23170, -23170, -11585, -11585);
        drain();

        // Wrap and truncation
        send_exp(16'hFFFF, 15'h7FFF, -201, 32767, -201, 32766);
        send_exp(16'h003F, 15'h7FFF, 0, 32767, 0, 32766);
        drain();

        // Backpressure mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(PW'($urandom), MW'($urandom), 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #2 out_ready = 1'b0;
                @(negedge clk);
                check("bp_in_ready_low", rdy_s, 0);
                repeat (5) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with samples in flight
        for (int i = 0; i < 4; i++) send(PW'($urandom), MW'($urandom), 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", ov_s, 0);
        check("mid_rst_g0", g0_s, 0);
        check("mid_rst_g1", g1_s, 0);
        check("mid_rst_g0_raw", g0_r, 0);
        sbq.delete();
        @(posedge clk); #2;
        rst = 1'b1;
        send(16'h1357, 15'h5555, 1'b1);
        drain();

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    send(PW'($urandom), MW'($urandom), 1'b0);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #2;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #2;
                    if (!rnd_done) out_ready = ($urandom_range(0, 9) < 7);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();
        repeat (6) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
